// File: rtl/axisv_pkg.sv
`default_nettype none
// ============================================================================
// axisv_pkg : shared state encoding and sync-window helper for the LCD sink.
// Revision  : 1.0
// ============================================================================
package axisv_pkg;

  localparam logic [1:0] C_ST_WAIT_SOF = 2'd0;
  localparam logic [1:0] C_ST_ALIGNED  = 2'd1;
  localparam logic [1:0] C_ST_DRAIN    = 2'd2;

  typedef enum logic [1:0] {
    WAIT_SOF = C_ST_WAIT_SOF,
    ALIGNED  = C_ST_ALIGNED,
    DRAIN    = C_ST_DRAIN
  } lcd_state_e;

  // True when cnt lies in the half-open window [start, start+width).
  function automatic logic in_window(input int unsigned cnt,
                                     input int unsigned start,
                                     input int unsigned width);
    return (cnt >= start) && (cnt < start + width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axisv_lcd_drv_if.sv
`default_nettype none
// ============================================================================
// axisv_lcd_drv_if : AXI4-Stream video beat bus (pixel, EOL, EOF markers).
// Revision         : 1.0
// ============================================================================
interface axisv_lcd_drv_if #(
  parameter int DATA_WIDTH = 18
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axisv_raster_gen.sv
`default_nettype none
// ============================================================================
// axisv_raster_gen : free-running h/v raster counters with active/sync decode.
// Revision         : 1.0
// ============================================================================
module axisv_raster_gen
  import axisv_pkg::*;
#(
  parameter int  H_PIXEL_COUNT = 8,
  parameter int  V_PIXEL_COUNT = 4,
  parameter int  H_FRONT_PORCH = 2,
  parameter int  H_SYNC_WIDTH  = 2,
  parameter int  H_BACK_PORCH  = 2,
  parameter int  V_FRONT_PORCH = 1,
  parameter int  V_SYNC_WIDTH  = 1,
  parameter int  V_BACK_PORCH  = 1,
  localparam int H_TOTAL = H_PIXEL_COUNT + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int V_TOTAL = V_PIXEL_COUNT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int H_CNT_W = $clog2(H_TOTAL),
  localparam int V_CNT_W = $clog2(V_TOTAL)
) (
  input  logic               aclk_i,
  input  logic               rst_ni,
  output logic [H_CNT_W-1:0] h_cnt_o,
  output logic [V_CNT_W-1:0] v_cnt_o,
  output logic               active_o,
  output logic               hsync_raw_o,
  output logic               vsync_raw_o
);

  localparam logic [H_CNT_W-1:0] C_H_LAST = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] C_V_LAST = V_CNT_W'(V_TOTAL - 1);

  logic [H_CNT_W-1:0] r_h_cnt;
  logic [V_CNT_W-1:0] r_v_cnt;

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == C_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign h_cnt_o     = r_h_cnt;
  assign v_cnt_o     = r_v_cnt;
  assign active_o    = (32'(r_h_cnt) < H_PIXEL_COUNT) && (32'(r_v_cnt) < V_PIXEL_COUNT);
  assign hsync_raw_o = in_window(32'(r_h_cnt), H_PIXEL_COUNT + H_FRONT_PORCH, H_SYNC_WIDTH);
  assign vsync_raw_o = in_window(32'(r_v_cnt), V_PIXEL_COUNT + V_FRONT_PORCH, V_SYNC_WIDTH);

endmodule
`default_nettype wire

// File: rtl/axisv_lcd_drv.sv
`default_nettype none
// ============================================================================
// axisv_lcd_drv : AXI4-Stream video sink driving a parallel RGB LCD panel,
//                 checking stream framing against the raster and re-locking.
// Revision      : 1.0
// ============================================================================
module axisv_lcd_drv
  import axisv_pkg::*;
#(
  parameter int  H_PIXEL_COUNT = 8,
  parameter int  V_PIXEL_COUNT = 4,
  parameter int  H_FRONT_PORCH = 2,
  parameter int  H_SYNC_WIDTH  = 2,
  parameter int  H_BACK_PORCH  = 2,
  parameter int  V_FRONT_PORCH = 1,
  parameter int  V_SYNC_WIDTH  = 1,
  parameter int  V_BACK_PORCH  = 1,
  parameter bit  HSYNC_POL     = 1'b0,
  parameter bit  VSYNC_POL     = 1'b0,
  parameter int  DATA_WIDTH    = 18,
  localparam int H_TOTAL = H_PIXEL_COUNT + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int V_TOTAL = V_PIXEL_COUNT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int H_CNT_W = $clog2(H_TOTAL),
  localparam int V_CNT_W = $clog2(V_TOTAL)
) (
  input  logic                  aclk_i,
  input  logic                  rst_ni,
  axisv_lcd_drv_if.slave        s_axis,
  output logic [DATA_WIDTH-1:0] lcd_data_o,
  output logic                  lcd_de_o,
  output logic                  lcd_hsync_o,
  output logic                  lcd_vsync_o,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o
);

  localparam logic [H_CNT_W-1:0] C_H_PIX_LAST = H_CNT_W'(H_PIXEL_COUNT - 1);
  localparam logic [V_CNT_W-1:0] C_V_PIX_LAST = V_CNT_W'(V_PIXEL_COUNT - 1);

  logic [H_CNT_W-1:0] w_h_cnt;
  logic [V_CNT_W-1:0] w_v_cnt;
  logic               w_active, w_hsync_raw, w_vsync_raw;

  axisv_raster_gen #(
    .H_PIXEL_COUNT (H_PIXEL_COUNT),
    .V_PIXEL_COUNT (V_PIXEL_COUNT),
    .H_FRONT_PORCH (H_FRONT_PORCH),
    .H_SYNC_WIDTH  (H_SYNC_WIDTH),
    .H_BACK_PORCH  (H_BACK_PORCH),
    .V_FRONT_PORCH (V_FRONT_PORCH),
    .V_SYNC_WIDTH  (V_SYNC_WIDTH),
    .V_BACK_PORCH  (V_BACK_PORCH)
  ) u_raster (
    .aclk_i      (aclk_i),
    .rst_ni      (rst_ni),
    .h_cnt_o     (w_h_cnt),
    .v_cnt_o     (w_v_cnt),
    .active_o    (w_active),
    .hsync_raw_o (w_hsync_raw),
    .vsync_raw_o (w_vsync_raw)
  );

  lcd_state_e            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_de, r_hsync, r_vsync, r_err;
  logic [7:0]            r_err_cnt;
  logic                  w_tready, w_acc, w_exp_last, w_exp_user, w_err, w_show;

  assign w_exp_last = (w_h_cnt == C_H_PIX_LAST);
  assign w_exp_user = w_exp_last && (w_v_cnt == C_V_PIX_LAST);

  always_comb begin
    w_tready    = 1'b0;
    w_acc       = 1'b0;
    w_err       = 1'b0;
    w_show      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      WAIT_SOF: w_tready = (w_h_cnt == '0) && (w_v_cnt == '0);
      ALIGNED:  w_tready = w_active;
      DRAIN:    w_tready = 1'b1;
      default:  w_tready = 1'b0;
    endcase
    w_acc = s_axis.tvalid && w_tready;
    case (r_state)
      WAIT_SOF: begin
        if (w_acc) begin
          w_show      = 1'b1;
          w_state_nxt = ALIGNED;
        end
      end
      ALIGNED: begin
        if (w_active) begin
          if (!s_axis.tvalid) begin
            w_err       = 1'b1;
            w_state_nxt = DRAIN;
          end else if ((s_axis.tlast != w_exp_last) || (s_axis.tuser != w_exp_user)) begin
            // A bad beat that still carries EOF has already closed the frame.
            w_err       = 1'b1;
            w_state_nxt = s_axis.tuser ? WAIT_SOF : DRAIN;
          end else begin
            w_show = 1'b1;
            if (w_exp_user) w_state_nxt = WAIT_SOF;
          end
        end
      end
      DRAIN: begin
        if (w_acc && s_axis.tuser) w_state_nxt = WAIT_SOF;
      end
      default: w_state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= WAIT_SOF;
      r_data    <= '0;
      r_de      <= 1'b0;
      r_hsync   <= ~HSYNC_POL;
      r_vsync   <= ~VSYNC_POL;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_show ? s_axis.tdata : '0;
      r_de    <= w_active;
      r_hsync <= w_hsync_raw ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_vsync_raw ? VSYNC_POL : ~VSYNC_POL;
      r_err   <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Held low through reset even though the counters then sit at (0,0).
  assign s_axis.tready = w_tready & rst_ni;
  assign lcd_data_o    = r_data;
  assign lcd_de_o      = r_de;
  assign lcd_hsync_o   = r_hsync;
  assign lcd_vsync_o   = r_vsync;
  assign locked_o      = (r_state == ALIGNED);
  assign err_o         = r_err;
  assign err_cnt_o     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axisv_lcd_drv.sv
`default_nettype none
// ============================================================================
// tb_axisv_lcd_drv : directed frames with a pixel scoreboard for axisv_lcd_drv.
// Revision         : 1.0
// ============================================================================
module tb_axisv_lcd_drv;

  localparam int DW      = 18;
  localparam int M_IDLE  = 0;
  localparam int M_GOOD  = 1;
  localparam int M_UNDER = 2;
  localparam int M_TLAST = 3;
  localparam int M_EARLY = 4;
  localparam int M_RST   = 5;

  logic          aclk  = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] lcd_data;
  logic          lcd_de, lcd_hs, lcd_vs, locked, err;
  logic [7:0]    err_cnt;

  axisv_lcd_drv_if #(.DATA_WIDTH(DW)) s_axis_if ();

  axisv_lcd_drv #(.DATA_WIDTH(DW)) dut (
    .aclk_i      (aclk),
    .rst_ni      (rst_n),
    .s_axis      (s_axis_if),
    .lcd_data_o  (lcd_data),
    .lcd_de_o    (lcd_de),
    .lcd_hsync_o (lcd_hs),
    .lcd_vsync_o (lcd_vs),
    .locked_o    (locked),
    .err_o       (err),
    .err_cnt_o   (err_cnt)
  );

  always #5 aclk = ~aclk;

  int            n_total    = 0;
  int            n_bad      = 0;
  int            err_seen   = 0;
  int            exp_cnt    = 0;
  int            prev_h     = 0;
  int            prev_v     = 0;
  bit            prev_valid = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r * 16 + c + 1);
  endfunction

  // Outputs seen now belong to the raster position of the previous cycle.
  task automatic check_sync();
    logic [2:0] e;
    if (!prev_valid) e = 3'b011;
    else e = {(prev_h < 8) && (prev_v < 4), !((prev_h >= 10) && (prev_h < 12)), !(prev_v == 5)};
    check("sync_de_hs_vs", 32'({lcd_de, lcd_hs, lcd_vs}), 32'(e));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {lcd_data, lcd_de, lcd_hs, lcd_vs, s_axis_if.tready, locked, err, err_cnt},
          {18'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
  endtask

  // Monitor: pop one expected pixel per DE-high output cycle.
  initial begin
    forever begin
      @(negedge aclk);
      if (rst_n) begin
        if (lcd_de) begin
          if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL pix_order: DE high with empty scoreboard, data=%0h at %0t", lcd_data, $time);
          end else begin
            check("pix_data", 32'(lcd_data), 32'(exp_q.pop_front()));
          end
        end else begin
          check("blank_data", 32'(lcd_data), 32'd0);
        end
        if (err) err_seen++;
      end
    end
  end

  task automatic run_frame(input int mode, input int er, input int ec);
    bit            bad   = 1'b0;
    bit            ended = 1'b0;
    bit            hit;
    int            base  = err_seen;
    int            nerr  = (mode == M_UNDER || mode == M_TLAST || mode == M_EARLY) ? 1 : 0;
    logic [DW-1:0] e;
    for (int v = 0; v < 7; v++) begin
      for (int h = 0; h < 14; h++) begin
        @(negedge aclk);
        check_sync();
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tuser  = 1'b0;
        hit = (v == er) && (h == ec);
        if (mode == M_RST && hit) begin
          #3 rst_n = 1'b0;
          #1 check_reset_outputs("reset_async");
          exp_q.delete();
          exp_cnt = 0;
          repeat (3) @(posedge aclk);
          #2 rst_n = 1'b1;
          prev_valid = 1'b0;
          return;
        end
        if (h < 8 && v < 4) begin
          e = '0;
          if (mode != M_IDLE && !ended) begin
            s_axis_if.tvalid = 1'b1;
            s_axis_if.tdata  = pix(v, h);
            s_axis_if.tlast  = (h == 7);
            s_axis_if.tuser  = (h == 7) && (v == 3);
            if (hit && mode == M_UNDER) s_axis_if.tvalid = 1'b0;
            if (hit && mode == M_TLAST) s_axis_if.tlast  = 1'b1;
            if (hit && mode == M_EARLY) s_axis_if.tuser  = 1'b1;
          end
          if (hit && nerr == 1) begin
            bad = 1'b1;
            if (mode == M_EARLY) ended = 1'b1;
          end else if (mode != M_IDLE && !bad) begin
            e = pix(v, h);
          end
          exp_q.push_back(e);
        end
        #1;
        if (v == 0 && h == 0) check("tready_sof", 32'(s_axis_if.tready), 32'd1);
        if (v == 0 && h == 1) check("locked", 32'(locked), (mode == M_IDLE) ? 32'd0 : 32'd1);
        if (nerr == 1 && v == er && h == ec + 1) begin
          check("tready_after_err", 32'(s_axis_if.tready), (mode == M_EARLY) ? 32'd0 : 32'd1);
          check("locked_after_err", 32'(locked), 32'd0);
        end
        prev_h     = h;
        prev_v     = v;
        prev_valid = 1'b1;
      end
    end
    exp_cnt = (exp_cnt + nerr > 255) ? 255 : exp_cnt + nerr;
    check("err_pulses", 32'(err_seen - base), 32'(nerr));
    check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tdata  = '0;
    s_axis_if.tlast  = 1'b0;
    s_axis_if.tuser  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge aclk);
    #2 check_reset_outputs("reset_values");
    rst_n = 1'b1;

    run_frame(M_IDLE, -1, -1);
    run_frame(M_GOOD, -1, -1);
    run_frame(M_GOOD, -1, -1);
    run_frame(M_UNDER, 1, 3);
    run_frame(M_GOOD, -1, -1);
    run_frame(M_TLAST, 0, 5);
    run_frame(M_EARLY, 2, 7);
    run_frame(M_GOOD, -1, -1);
    run_frame(M_RST, 2, 4);
    run_frame(M_GOOD, -1, -1);
    repeat (300) run_frame(M_EARLY, 0, 1);
    run_frame(M_GOOD, -1, -1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
